idecode: RTL
============

Name: idecode

Overview:
- Decode/register-read stage directly downstream of the instruction fetch stage.
- Consumes the 64-bit instruction word and pc presented by fetch, and decodes type, opcode and register fields.
- Reads two operands from an internal 16x32 register file and tracks pending writes with a scoreboard.
- Presents a registered, decoded bundle to execute; back-pressures fetch on hazards or on execute stall.

Parameters:
- NREGS, 16, number of architectural registers (register index width = 4)
- DWIDTH, 32, register/data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ir_i  in  64  instruction from fetch; 64'h0 = bubble
- pc_i  in  32  pc associated with ir_i
- flush_i  in  1  pc_set from control; kill the instruction in decode
- stall_i  in  1  execute cannot accept this cycle
- stall_o  out  1  to fetch stall_i; hold ir_i/pc_i
- wb_we_i  in  1  writeback enable
- wb_reg_i  in  4  writeback register index
- wb_data_i  in  32  writeback data
- valid_o  out  1  output bundle holds a real instruction
- pc_o  out  32  registered pc
- type_o  out  4  ir[31:28]
- op_o  out  4  ir[27:24]
- dest_o  out  4  ir[23:20]
- dest_we_o  out  1  instruction writes dest_o
- a_data_o  out  32  operand A = R[rb]
- b_data_o  out  32  operand B = R[ra] for STORE, else R[rc]
- imm_o  out  32  immediate
- exc_o  out  1  illegal type, registered with bundle

Behaviour:
- Field map (low word): type [31:28], op [27:24], ra [23:20], rb [19:16], rc [15:12], imm15 [15:1], long flag [0].
- Long instruction (ir_i[0]=1): imm = ir_i[63:32]. Otherwise imm = sign-extend ir_i[15:1] to 32 bits.
- Types:
  - INH=0: no reads, no dest
  - REG=1: reads rb, rc; dest ra
  - IMM=2: reads rb; dest ra
  - LOAD=3: reads rb; dest ra
  - STORE=4: reads rb, ra; no dest
  - BRANCH=5: reads rb, rc; no dest
  - JUMP=6: no reads, no dest
  - 7-15: illegal. exc_o=1, dest_we_o=0, no reads.
- ir_i==0 is a bubble: not valid, no reads, no scoreboard effect.
- Scoreboard: one pending bit per register.
  - Set when an instruction with dest_we is latched into the output register.
  - Cleared on wb_we_i for wb_reg_i.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard: any source register pending and not cleared by writeback this cycle.
  - Without WB_BYPASS_EN, a source being written back this cycle also counts as a hazard.
- stall_o = stall_i | hazard.
- Output register update:
  - stall_i=1: hold all outputs.
  - Else if hazard or flush_i: latch a bubble (valid_o=0, dest_we_o=0, exc_o=0; other outputs hold).
  - Else: latch the decoded ir_i/pc_i and read data. Latency is 1 cycle from ir_i to the bundle.
- flush_i with valid_o=1 and stall_i=1: the bundle is killed (valid_o->0). Its scoreboard bit is cleared, unless the same register is re-set that cycle.
- Register file:
  - Synchronous write on wb_we_i.
  - Combinational read, sampled into the output register.
  - A same-cycle write to a read register returns the new data, because the bypass mux is always present in the read path.
- Reset: all outputs 0, scoreboard cleared, register file contents cleared to 0.

Optional Feature:
- Macro: IDECODE_WB_BYPASS_EN.
- Defined: a writeback in the same cycle resolves the hazard for that register. Operand data comes from wb_data_i.
- Undefined: the instruction stalls one extra cycle until the pending bit has cleared. Register-file bypass is still used for data.

Decomposition:
- Package bexkat1Def holds:
  - typedef enum for instruction type (T_INH..T_JUMP)
  - field position localparams
  - a struct for the decoded bundle (valid, pc, type, op, dest, dest_we, a, b, imm, exc)
- Sub-module regfile: 2 async read ports, 1 sync write port, internal write-to-read bypass, async reset.
- Scoreboard and decode remain in idecode.

Test Plan:
- Reset, then REG instruction ir_i=32'h1123_4000 (ra=2, rb=3, rc=4) with R3=5, R4=7 -> next cycle valid_o=1, type_o=1, dest_o=2, a_data_o=5, b_data_o=7, dest_we_o=1; scoreboard[2]=1.
- Back-to-back REG writing R2, then IMM reading rb=2 -> stall_o=1 and bubble out until wb_we_i with wb_reg_i=2. With bypass, issue occurs in the writeback cycle with a_data_o=wb_data_i; without bypass, one cycle later.
- Long JUMP ir_i={32'hDEAD_BEEF, 32'h6000_0001} -> imm_o=32'hDEAD_BEEF, dest_we_o=0, no stall.
- Short IMM with ir_i[15:1]=15'h7FFF -> imm_o=32'hFFFF_FFFF. With 15'h0001 -> imm_o=1.
- flush_i while a valid REG (dest R5) is held under stall_i=1 -> valid_o=0 next cycle, scoreboard[5]=0, exc_o=0.
- Type 4'hA instruction -> exc_o=1, dest_we_o=0, scoreboard unchanged. Assert rst_i mid-stream -> all outputs and scoreboard immediately 0.

Source files
------------

// File: rtl/idecode_pkg.sv
// Shared decode definitions for the bexkat1 decode stage.
// Instruction types, field positions and the decoded bundle.
package bexkat1Def;

    localparam int NREGS    = 16;
    localparam int DWIDTH   = 32;
    localparam int RIDX     = 4;

    localparam int TYPE_LSB = 28;
    localparam int OP_LSB   = 24;
    localparam int RA_LSB   = 20;
    localparam int RB_LSB   = 16;
    localparam int RC_LSB   = 12;
    localparam int IMM_LSB  = 1;
    localparam int IMM_W    = 15;
    localparam int LONG_BIT = 0;

    typedef enum logic [3:0] {
        T_INH    = 4'd0,
        T_REG    = 4'd1,
        T_IMM    = 4'd2,
        T_LOAD   = 4'd3,
        T_STORE  = 4'd4,
        T_BRANCH = 4'd5,
        T_JUMP   = 4'd6
    } itype_e;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [3:0]        typ;
        logic [3:0]        op;
        logic [RIDX-1:0]   dest;
        logic              dest_we;
        logic [DWIDTH-1:0] a;
        logic [DWIDTH-1:0] b;
        logic [31:0]       imm;
        logic              exc;
    } bundle_t;

    function automatic logic [31:0] sext15(input logic [IMM_W-1:0] v);
        return {{(32-IMM_W){v[IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 16x32 register file: two combinational read ports, one write port.
// Reads see a same-cycle write through the internal bypass.
module idecode_regfile
    import bexkat1Def::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [3:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);

    logic [DWIDTH-1:0] mem_q [NREGS];
    logic [DWIDTH-1:0] mem_d [NREGS];

    // Next-state array; reads come from it so writes bypass to readers.
    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    assign rdata_a_o = mem_d[raddr_a_i];
    assign rdata_b_o = mem_d[raddr_b_i];

    // Storage, cleared on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/idecode.sv
// Decode/register-read stage with pending-write scoreboard.
// IDECODE_WB_BYPASS_EN: same-cycle writeback resolves hazards.
module idecode
    import bexkat1Def::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        stall_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_reg_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [3:0]  type_o,
    output logic [3:0]  op_o,
    output logic [3:0]  dest_o,
    output logic        dest_we_o,
    output logic [31:0] a_data_o,
    output logic [31:0] b_data_o,
    output logic [31:0] imm_o,
    output logic        exc_o
);

    logic [3:0]  typ, op, ra, rb, rc, b_idx;
    logic        rd_a, rd_b, rd_c, dwe, ill, bub;
    logic [31:0] imm, a_rdata, b_rdata;
    logic [15:0] wb_hit, busy, sb_q, sb_d;
    logic        hazard, load, kill;
    bundle_t     out_q, out_d;

    assign typ   = ir_i[TYPE_LSB +: 4];
    assign op    = ir_i[OP_LSB +: 4];
    assign ra    = ir_i[RA_LSB +: 4];
    assign rb    = ir_i[RB_LSB +: 4];
    assign rc    = ir_i[RC_LSB +: 4];
    assign bub   = (ir_i == 64'h0);
    assign imm   = ir_i[LONG_BIT] ? ir_i[63:32]
                                  : sext15(ir_i[IMM_LSB +: IMM_W]);
    assign b_idx = (typ == T_STORE) ? ra : rc;

    // Per-type source usage and destination write.
    always_comb begin
        rd_a = 1'b0;
        rd_b = 1'b0;
        rd_c = 1'b0;
        dwe  = 1'b0;
        ill  = 1'b0;
        case (typ)
            T_INH:    ;
            T_REG:    begin rd_b = 1'b1; rd_c = 1'b1; dwe = 1'b1; end
            T_IMM:    begin rd_b = 1'b1; dwe = 1'b1; end
            T_LOAD:   begin rd_b = 1'b1; dwe = 1'b1; end
            T_STORE:  begin rd_b = 1'b1; rd_a = 1'b1; end
            T_BRANCH: begin rd_b = 1'b1; rd_c = 1'b1; end
            T_JUMP:   ;
            default:  ill = 1'b1;
        endcase
    end

    idecode_regfile u_rf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wb_we_i),
        .waddr_i   (wb_reg_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (rb),
        .rdata_a_o (a_rdata),
        .raddr_b_i (b_idx),
        .rdata_b_o (b_rdata)
    );

    // Registers that block a reader this cycle.
    always_comb begin
        wb_hit = wb_we_i ? (16'h1 << wb_reg_i) : 16'h0;
`ifdef IDECODE_WB_BYPASS_EN
        busy = sb_q & ~wb_hit;
`else
        busy = sb_q | wb_hit;
`endif
        hazard = (rd_b & busy[rb]) | (rd_c & busy[rc]) | (rd_a & busy[ra]);
    end

    assign stall_o = stall_i | hazard;
    assign load    = !stall_i && !hazard && !flush_i && !bub;
    assign kill    = flush_i && stall_i && out_q.valid && out_q.dest_we;

    // Output bundle: hold on stall, bubble on hazard/flush, else latch.
    always_comb begin
        out_d = out_q;
        if (load) begin
            out_d.valid   = 1'b1;
            out_d.pc      = pc_i;
            out_d.typ     = typ;
            out_d.op      = op;
            out_d.dest    = ra;
            out_d.dest_we = dwe;
            out_d.a       = a_rdata;
            out_d.b       = b_rdata;
            out_d.imm     = imm;
            out_d.exc     = ill;
        end else if (!stall_i || flush_i) begin
            out_d.valid   = 1'b0;
            out_d.dest_we = 1'b0;
            out_d.exc     = 1'b0;
        end
    end

    // Pending bits: clear on writeback or kill, set on issue (set wins).
    always_comb begin
        sb_d = sb_q;
        if (wb_we_i) sb_d[wb_reg_i] = 1'b0;
        if (kill) sb_d[out_q.dest] = 1'b0;
        if (load && dwe) sb_d[ra] = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
            sb_q  <= '0;
        end else begin
            out_q <= out_d;
            sb_q  <= sb_d;
        end
    end

    assign valid_o   = out_q.valid;
    assign pc_o      = out_q.pc;
    assign type_o    = out_q.typ;
    assign op_o      = out_q.op;
    assign dest_o    = out_q.dest;
    assign dest_we_o = out_q.dest_we;
    assign a_data_o  = out_q.a;
    assign b_data_o  = out_q.b;
    assign imm_o     = out_q.imm;
    assign exc_o     = out_q.exc;

endmodule
